// File: rtl/tt_pkg.sv
// Shared types and width helpers for the truth-table sweeper.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_e;

    // Wide enough for settle values up to 15.
    localparam int SETTLE_W = 4;

    function automatic int table_width(input int nin);
        return 1 << nin;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Signal bundle around one sweeper: stimulus side (master) and sweeper side (slave).
// Optional 'ones' member is present only when TT_ONES_COUNT_EN is defined.
interface truth_table_sweeper_if #(
    parameter int NIN = 4
) ();
    import tt_pkg::*;

    // Handshake: start is a level request, honoured only when busy=0; done stays
    // high, with table_out frozen, until the next accepted start.
    logic                          start;
    logic                          s_in;
    logic [NIN-1:0]                vec;
    logic                          busy;
    logic                          done;
    logic [table_width(NIN)-1:0]   table_out;
    tt_state_e                     fsm_state;
`ifdef TT_ONES_COUNT_EN
    logic [NIN:0]                  ones;
`endif

    modport master (
        output start, s_in,
        input  vec, busy, done, table_out, fsm_state
`ifdef TT_ONES_COUNT_EN
        , input ones
`endif
    );

    modport slave (
        input  start, s_in,
        output vec, busy, done, table_out, fsm_state
`ifdef TT_ONES_COUNT_EN
        , output ones
`endif
    );

endinterface

// File: rtl/tt_vec_counter.sv
// Vector counter plus settle counter for the sweeper; vec saturates at all ones.
module tt_vec_counter
    import tt_pkg::*;
#(
    parameter int NIN    = 4,
    parameter int SETTLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           settle_inc,
    input  logic           vec_inc,
    output logic [NIN-1:0] vec,
    output logic           last_vec,
    output logic           settle_done
);

    logic [SETTLE_W-1:0] settle_cnt;

    assign last_vec    = (vec == {NIN{1'b1}});
    assign settle_done = (settle_cnt == SETTLE_W'(SETTLE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec        <= '0;
            settle_cnt <= '0;
        end else if (clr) begin
            vec        <= '0;
            settle_cnt <= '0;
        end else if (vec_inc) begin
            // Moving to the next vector restarts the settle window.
            settle_cnt <= '0;
            if (!last_vec)
                vec <= vec + NIN'(1);
        end else if (settle_inc) begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of a combinational function and records its truth table.
// Build option: TT_ONES_COUNT_EN adds a registered count of 1 bits in the table.
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int NIN    = 4,
    parameter int SETTLE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        s_in,
    output logic [NIN-1:0]              vec,
    output logic                        busy,
    output logic                        done,
    output logic [table_width(NIN)-1:0] table_out,
`ifdef TT_ONES_COUNT_EN
    output logic [NIN:0]                ones,
`endif
    output tt_state_e                   fsm_state
);

    tt_state_e state;
    logic      clr;
    logic      settle_inc;
    logic      vec_inc;
    logic      last_vec;
    logic      settle_done;

    assign fsm_state = state;

    tt_vec_counter #(
        .NIN    (NIN),
        .SETTLE (SETTLE)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .settle_inc  (settle_inc),
        .vec_inc     (vec_inc),
        .vec         (vec),
        .last_vec    (last_vec),
        .settle_done (settle_done)
    );

    always_comb begin
        clr        = 1'b0;
        settle_inc = 1'b0;
        vec_inc    = 1'b0;
        case (state)
            IDLE, DONE: clr        = start;
            DRIVE:      settle_inc = !settle_done;
            SAMPLE:     vec_inc    = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= '0;
`ifdef TT_ONES_COUNT_EN
            ones      <= '0;
`endif
        end else begin
            case (state)
                // start is only looked at here, so it is ignored while busy.
                IDLE, DONE: begin
                    if (start) begin
                        state     <= DRIVE;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        table_out <= '0;
`ifdef TT_ONES_COUNT_EN
                        ones      <= '0;
`endif
                    end
                end
                DRIVE: begin
                    if (settle_done)
                        state <= SAMPLE;
                end
                SAMPLE: begin
                    table_out[vec] <= s_in;
`ifdef TT_ONES_COUNT_EN
                    ones <= ones + {{NIN{1'b0}}, s_in};
`endif
                    if (last_vec) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE=1 and SETTLE=3) checked
// against a truth-table model computed from the function definitions.
module tb_truth_table_sweeper;
    import tt_pkg::*;

    localparam int NIN = 4;
    localparam int NV  = 1 << NIN;

    // Function modes applied to s_in.
    localparam int F_ZERO = 0;
    localparam int F_XOR  = 1;
    localparam int F_AND  = 2;
    localparam int F_OR   = 3;
    localparam int F_LUT  = 4;

    logic clk;
    logic rst;

    int          mode_a, mode_b;
    logic [15:0] lut_a, lut_b;
    int          n_checks;
    int          n_pass;

    truth_table_sweeper_if #(.NIN(NIN)) ifa ();
    truth_table_sweeper_if #(.NIN(NIN)) ifb ();

    truth_table_sweeper #(.NIN(NIN), .SETTLE(1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .start     (ifa.start),
        .s_in      (ifa.s_in),
        .vec       (ifa.vec),
        .busy      (ifa.busy),
        .done      (ifa.done),
        .table_out (ifa.table_out),
`ifdef TT_ONES_COUNT_EN
        .ones      (ifa.ones),
`endif
        .fsm_state (ifa.fsm_state)
    );

    truth_table_sweeper #(.NIN(NIN), .SETTLE(3)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (ifb.start),
        .s_in      (ifb.s_in),
        .vec       (ifb.vec),
        .busy      (ifb.busy),
        .done      (ifb.done),
        .table_out (ifb.table_out),
`ifdef TT_ONES_COUNT_EN
        .ones      (ifb.ones),
`endif
        .fsm_state (ifb.fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- function under test ----------------
    function automatic logic func_out(input int mode, input logic [15:0] lut, input logic [3:0] v);
        case (mode)
            F_XOR:   return ^v;
            F_AND:   return &v;
            F_OR:    return |v;
            F_LUT:   return lut[v];
            default: return 1'b0;
        endcase
    endfunction

    always_comb ifa.s_in = func_out(mode_a, lut_a, ifa.vec);
    always_comb ifb.s_in = func_out(mode_b, lut_b, ifb.vec);

    // ---------------- reference model ----------------
    function automatic logic model_bit(input int mode, input logic [15:0] lut, input int i);
        case (mode)
            F_XOR:   return ($countones(i) % 2) == 1;
            F_AND:   return i == NV - 1;
            F_OR:    return i != 0;
            F_LUT:   return lut[i];
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- per-instance access ----------------
    task automatic set_start(input int sel, input logic v);
        if (sel == 0) ifa.start = v;
        else          ifb.start = v;
    endtask

    function automatic logic [15:0] get_tbl(input int sel);
        return (sel == 0) ? ifa.table_out : ifb.table_out;
    endfunction

    function automatic logic [3:0] get_vec(input int sel);
        return (sel == 0) ? ifa.vec : ifb.vec;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? ifa.busy : ifb.busy;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? ifa.done : ifb.done;
    endfunction

`ifdef TT_ONES_COUNT_EN
    function automatic logic [4:0] get_ones(input int sel);
        return (sel == 0) ? ifa.ones : ifb.ones;
    endfunction
`endif

    // ---------------- driver: one full sweep, optional start poke at vec==poke ----------------
    task automatic run_sweep(input int sel, input int mode, input logic [15:0] lut, input int poke);
        int          settle;
        int          exp_cyc;
        int          n;
        int          exp_ones;
        bit          poked;
        logic [15:0] exp_tbl;
        logic [31:0] exp_q[$];

        settle = (sel == 0) ? 1 : 3;
        if (sel == 0) begin mode_a = mode; lut_a = lut; end
        else          begin mode_b = mode; lut_b = lut; end

        exp_tbl  = '0;
        exp_ones = 0;
        for (int i = 0; i < NV; i++) begin
            exp_tbl[i] = model_bit(mode, lut, i);
            if (exp_tbl[i]) exp_ones++;
        end
        exp_cyc = NV * (settle + 1);
        exp_q.push_back(32'(exp_cyc));
        exp_q.push_back(32'(exp_tbl));

        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
        check("start_busy", 32'(get_busy(sel)), 32'd1);
        check("start_done_low", 32'(get_done(sel)), 32'd0);
        check("start_vec0", 32'(get_vec(sel)), 32'd0);
        check("start_tbl_clr", 32'(get_tbl(sel)), 32'd0);

        n     = 0;
        poked = 1'b0;
        while (n < 300) begin
            @(posedge clk);
            n++;
            #1;
            set_start(sel, 1'b0);
            if (get_done(sel)) break;
            if (poke >= 0 && !poked && get_vec(sel) == 4'(poke)) begin
                set_start(sel, 1'b1);
                poked = 1'b1;
            end
        end
        set_start(sel, 1'b0);

        check("done_edge", 32'(n), exp_q.pop_front());
        check("done_tbl", 32'(get_tbl(sel)), exp_q.pop_front());
        check("done_busy_low", 32'(get_busy(sel)), 32'd0);
        check("done_vec_ones", 32'(get_vec(sel)), 32'hF);
`ifdef TT_ONES_COUNT_EN
        check("done_ones", 32'(get_ones(sel)), 32'(exp_ones));
`endif
        // Table must stay frozen while parked in DONE.
        repeat (3) @(posedge clk);
        #1;
        check("done_stable", 32'(get_tbl(sel)), 32'(exp_tbl));
        check("done_hold", 32'(get_done(sel)), 32'd1);
    endtask

    // ---------------- reset in the middle of a sweep ----------------
    task automatic reset_mid_sweep(input int at_vec);
        int n;
        mode_a = F_XOR;
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
        n = 0;
        while (ifa.vec != 4'(at_vec) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_vec", 32'(ifa.vec), 32'(at_vec));
        check("partial_tbl_nonzero", 32'(ifa.table_out != 16'h0), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_vec", 32'(ifa.vec), 32'd0);
        check("arst_busy", 32'(ifa.busy), 32'd0);
        check("arst_done", 32'(ifa.done), 32'd0);
        check("arst_tbl", 32'(ifa.table_out), 32'd0);
        check("arst_state", 32'(ifa.fsm_state), 32'(IDLE));
`ifdef TT_ONES_COUNT_EN
        check("arst_ones", 32'(ifa.ones), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks  = 0;
        n_pass    = 0;
        mode_a    = F_ZERO;
        mode_b    = F_ZERO;
        lut_a     = '0;
        lut_b     = '0;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        rst       = 1'b1;

        #3;
        check("rst_vec_a", 32'(ifa.vec), 32'd0);
        check("rst_busy_a", 32'(ifa.busy), 32'd0);
        check("rst_done_a", 32'(ifa.done), 32'd0);
        check("rst_tbl_a", 32'(ifa.table_out), 32'd0);
        check("rst_tbl_b", 32'(ifb.table_out), 32'd0);
        check("rst_state_b", 32'(ifb.fsm_state), 32'(IDLE));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_start", 32'(ifa.busy), 32'd0);

        run_sweep(0, F_ZERO, 16'h0, -1);
        check("zero_tbl_lit", 32'(ifa.table_out), 32'h0000);

        run_sweep(0, F_XOR, 16'h0, -1);
        check("xor_tbl_lit", 32'(ifa.table_out), 32'h6996);
`ifdef TT_ONES_COUNT_EN
        check("xor_ones_lit", 32'(ifa.ones), 32'd8);
`endif

        run_sweep(1, F_AND, 16'h0, -1);
        check("and_tbl_lit", 32'(ifb.table_out), 32'h8000);

        reset_mid_sweep(7);
        run_sweep(0, F_LUT, 16'($urandom), -1);

        run_sweep(0, F_AND, 16'h0, 5);
        check("poke_and_lit", 32'(ifa.table_out), 32'h8000);

        run_sweep(0, F_OR, 16'h0, -1);
        check("or_tbl_lit", 32'(ifa.table_out), 32'hFFFE);

        for (int k = 0; k < 3; k++) begin
            run_sweep(0, F_LUT, 16'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 13)) : -1);
            run_sweep(1, F_LUT, 16'($urandom), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
